// File: rtl/multi_phase_pwm_driver.sv
// N-phase half-bridge PWM generator: shared edge/center-aligned counter, double-buffered duty,
// per-phase dead-time FSM and a latched fault that forces every gate off.
module multi_phase_pwm_driver #(
    parameter int NUM_PHASES     = 3,
    parameter int COUNTER_WIDTH  = 10,
    parameter int PERIOD         = 1000,
    parameter int DEAD_TIME      = 8,
    parameter bit CENTER_ALIGNED = 1'b0
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_PHASES*COUNTER_WIDTH-1:0] duty,
    input  logic                                duty_load,
    input  logic [NUM_PHASES-1:0]               high_z,
    input  logic                                fault,
    input  logic                                fault_clear,
    output logic [NUM_PHASES-1:0]               pwm_high,
    output logic [NUM_PHASES-1:0]               pwm_low,
    output logic                                period_start,
    output logic                                update_ack,
    output logic                                fault_latched
);

    localparam logic [COUNTER_WIDTH-1:0] PERIOD_C = COUNTER_WIDTH'(PERIOD);
    localparam logic [COUNTER_WIDTH-1:0] LAST_UP  = COUNTER_WIDTH'(PERIOD - 1);
    localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);
    localparam logic [7:0]               DT_LAST  = 8'(DEAD_TIME - 1);

    typedef enum logic [1:0] {
        PH_OFF   = 2'd0,
        PH_HS_ON = 2'd1,
        PH_LS_ON = 2'd2,
        PH_DEAD  = 2'd3
    } phase_state_t;

    logic [COUNTER_WIDTH-1:0] count;
    logic                     count_up;
    logic                     boundary;
    logic                     pending_flag;

    // boundary marks the cycle whose closing edge brings the counter back to zero
    always_comb begin
        if (CENTER_ALIGNED) begin
            boundary = !count_up && (count == ONE);
        end else begin
            boundary = (count == LAST_UP);
        end
    end

    assign period_start = (count == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            count_up <= 1'b1;
        end else if (CENTER_ALIGNED) begin
            if (count_up) begin
                if (count == PERIOD_C) begin
                    count    <= count - ONE;
                    count_up <= 1'b0;
                end else begin
                    count <= count + ONE;
                end
            end else begin
                if (count == ONE) begin
                    count_up <= 1'b1;
                end
                count <= count - ONE;
            end
        end else begin
            if (boundary) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

    // a load in the boundary cycle itself is taken directly, so it also acknowledges
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_flag <= 1'b0;
            update_ack   <= 1'b0;
        end else begin
            update_ack <= boundary && (duty_load || pending_flag);
            if (boundary) begin
                pending_flag <= 1'b0;
            end else if (duty_load) begin
                pending_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clear) begin
            fault_latched <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
        logic [COUNTER_WIDTH-1:0] duty_raw;
        logic [COUNTER_WIDTH-1:0] duty_clamped;
        logic [COUNTER_WIDTH-1:0] pending_duty;
        logic [COUNTER_WIDTH-1:0] active_duty;
        logic                     ideal_hi;
        logic                     force_off;
        phase_state_t             state;
        logic [7:0]               dt_cnt;
        logic                     hi_q;
        logic                     lo_q;

        assign duty_raw     = duty[k*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign duty_clamped = (duty_raw > PERIOD_C) ? PERIOD_C : duty_raw;
        assign ideal_hi     = (active_duty == PERIOD_C) || (count < active_duty);
        // the raw fault input also forces off so the gates drop on the very next edge
        assign force_off    = high_z[k] || fault || fault_latched;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                pending_duty <= '0;
                active_duty  <= '0;
            end else begin
                if (duty_load) begin
                    pending_duty <= duty_clamped;
                end
                if (boundary) begin
                    if (duty_load) begin
                        active_duty <= duty_clamped;
                    end else if (pending_flag) begin
                        active_duty <= pending_duty;
                    end
                end
            end
        end

        // every switchover passes through DEAD; the target side is decided only on exit
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state  <= PH_OFF;
                dt_cnt <= '0;
                hi_q   <= 1'b0;
                lo_q   <= 1'b0;
            end else if (force_off) begin
                state  <= PH_OFF;
                dt_cnt <= '0;
                hi_q   <= 1'b0;
                lo_q   <= 1'b0;
            end else begin
                case (state)
                    PH_OFF: begin
                        state  <= PH_DEAD;
                        dt_cnt <= '0;
                        hi_q   <= 1'b0;
                        lo_q   <= 1'b0;
                    end
                    PH_HS_ON: begin
                        if (!ideal_hi) begin
                            state  <= PH_DEAD;
                            dt_cnt <= '0;
                            hi_q   <= 1'b0;
                            lo_q   <= 1'b0;
                        end
                    end
                    PH_LS_ON: begin
                        if (ideal_hi) begin
                            state  <= PH_DEAD;
                            dt_cnt <= '0;
                            hi_q   <= 1'b0;
                            lo_q   <= 1'b0;
                        end
                    end
                    PH_DEAD: begin
                        if (dt_cnt == DT_LAST) begin
                            state <= ideal_hi ? PH_HS_ON : PH_LS_ON;
                            hi_q  <= ideal_hi;
                            lo_q  <= !ideal_hi;
                        end else begin
                            dt_cnt <= dt_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= PH_OFF;
                        hi_q  <= 1'b0;
                        lo_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign pwm_high[k] = hi_q;
        assign pwm_low[k]  = lo_q;
    end

endmodule

// File: tb/tb_multi_phase_pwm_driver.sv
// Directed bench: one edge-aligned and one center-aligned instance (PERIOD=100, DEAD_TIME=4).
module tb_multi_phase_pwm_driver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [29:0] e_duty, c_duty;
    logic        e_duty_load, c_duty_load;
    logic [2:0]  e_high_z, c_high_z;
    logic        e_fault, e_fault_clear, c_fault, c_fault_clear;
    logic [2:0]  e_pwm_high, e_pwm_low, c_pwm_high, c_pwm_low;
    logic        e_period_start, e_update_ack, e_fault_latched;
    logic        c_period_start, c_update_ack, c_fault_latched;

    int n_compared = 0;
    int n_mismatched = 0;
    int edges = 0;

    always #5 clock = ~clock;

    // cycles since reset release; the DUT counter is derived from this
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    multi_phase_pwm_driver #(
        .NUM_PHASES(3), .COUNTER_WIDTH(10), .PERIOD(100), .DEAD_TIME(4), .CENTER_ALIGNED(1'b0)
    ) u_edge (
        .clock(clock), .reset_n(reset_n), .duty(e_duty), .duty_load(e_duty_load),
        .high_z(e_high_z), .fault(e_fault), .fault_clear(e_fault_clear),
        .pwm_high(e_pwm_high), .pwm_low(e_pwm_low), .period_start(e_period_start),
        .update_ack(e_update_ack), .fault_latched(e_fault_latched)
    );

    multi_phase_pwm_driver #(
        .NUM_PHASES(3), .COUNTER_WIDTH(10), .PERIOD(100), .DEAD_TIME(4), .CENTER_ALIGNED(1'b1)
    ) u_center (
        .clock(clock), .reset_n(reset_n), .duty(c_duty), .duty_load(c_duty_load),
        .high_z(c_high_z), .fault(c_fault), .fault_clear(c_fault_clear),
        .pwm_high(c_pwm_high), .pwm_low(c_pwm_low), .period_start(c_period_start),
        .update_ack(c_update_ack), .fault_latched(c_fault_latched)
    );

    function automatic logic [2:0] edge_hi(input int c, input int d);
        return (c >= 5 && c <= d) ? 3'b111 : 3'b000;
    endfunction

    function automatic logic [2:0] edge_lo(input int c, input int d);
        return (c == 0 || c >= d + 5) ? 3'b111 : 3'b000;
    endfunction

    task automatic goto_pos(input int modulus, input int target);
        for (int i = 0; i < modulus; i++) begin
            @(negedge clock);
            if (edges % modulus == target) return;
        end
    endtask

    task automatic load_edge(input logic [29:0] v);
        e_duty = v;
        e_duty_load = 1'b1;
        @(negedge clock);
        e_duty_load = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        e_duty = '0; c_duty = '0; e_duty_load = 1'b0; c_duty_load = 1'b0;
        e_high_z = '0; c_high_z = '0;
        e_fault = 1'b0; e_fault_clear = 1'b0; c_fault = 1'b0; c_fault_clear = 1'b0;
        repeat (3) @(negedge clock);
        n_compared++;
        if ({e_pwm_high, e_pwm_low, e_update_ack, e_fault_latched} !== 8'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000000",
                     {e_pwm_high, e_pwm_low, e_update_ack, e_fault_latched});
        end
        reset_n = 1'b1;
        #1;
        n_compared++;
        if (e_period_start !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL first_period_start: got %b expected 1", e_period_start);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            n_compared++;
            if (e_pwm_low !== ((k >= 5) ? 3'b111 : 3'b000) || e_pwm_high !== 3'b000) begin
                n_mismatched++;
                $display("[TB] FAIL reset_release_cycle%0d: got hi=%b lo=%b expected hi=000 lo=%b",
                         k, e_pwm_high, e_pwm_low, (k >= 5) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_duty_load;
        goto_pos(100, 10);
        load_edge({3{10'd50}});
        n_compared++;
        if (e_update_ack !== 1'b0 || e_pwm_low !== 3'b111) begin
            n_mismatched++;
            $display("[TB] FAIL load_not_yet_active: got ack=%b lo=%b expected ack=0 lo=111",
                     e_update_ack, e_pwm_low);
        end
        goto_pos(100, 0);
        n_compared++;
        if (e_update_ack !== 1'b1 || e_period_start !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ack_at_boundary: got ack=%b ps=%b expected 1 1",
                     e_update_ack, e_period_start);
        end
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clock);
            n_compared++;
            if (e_pwm_high !== edge_hi(c, 50) || e_pwm_low !== edge_lo(c, 50)) begin
                n_mismatched++;
                $display("[TB] FAIL duty50_count%0d: got hi=%b lo=%b expected hi=%b lo=%b",
                         c, e_pwm_high, e_pwm_low, edge_hi(c, 50), edge_lo(c, 50));
            end
            if (c == 1) begin
                n_compared++;
                if (e_update_ack !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL ack_one_cycle: got %b expected 0", e_update_ack);
                end
            end
        end
    endtask

    task automatic test_full_and_zero;
        goto_pos(100, 20);
        load_edge({10'd100, 10'd0, 10'd100});
        goto_pos(100, 10);
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clock);
            n_compared++;
            if (e_pwm_high !== 3'b101 || e_pwm_low !== 3'b010) begin
                n_mismatched++;
                $display("[TB] FAIL full_zero_step%0d: got hi=%b lo=%b expected hi=101 lo=010",
                         i, e_pwm_high, e_pwm_low);
            end
        end
    endtask

    task automatic test_swallow_and_clamp;
        logic [2:0] exp_lo;
        goto_pos(100, 20);
        load_edge({10'd0, 10'd150, 10'd2});
        goto_pos(100, 0);
        goto_pos(100, 0);
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clock);
            exp_lo = {1'b1, 1'b0, !(c >= 1 && c <= 4)};
            n_compared++;
            if (e_pwm_high !== 3'b010 || e_pwm_low !== exp_lo) begin
                n_mismatched++;
                $display("[TB] FAIL swallow_clamp_count%0d: got hi=%b lo=%b expected hi=010 lo=%b",
                         c, e_pwm_high, e_pwm_low, exp_lo);
            end
        end
    endtask

    task automatic test_fault;
        goto_pos(100, 20);
        load_edge({3{10'd50}});
        goto_pos(100, 20);
        n_compared++;
        if (e_pwm_high !== 3'b111) begin
            n_mismatched++;
            $display("[TB] FAIL pre_fault_high: got %b expected 111", e_pwm_high);
        end
        e_fault = 1'b1;
        @(negedge clock);
        n_compared++;
        if (e_pwm_high !== 3'b000 || e_pwm_low !== 3'b000 || e_fault_latched !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL fault_off: got hi=%b lo=%b latched=%b expected 000 000 1",
                     e_pwm_high, e_pwm_low, e_fault_latched);
        end
        e_fault_clear = 1'b1;
        @(negedge clock);
        n_compared++;
        if (e_fault_latched !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL clear_while_fault: got %b expected 1", e_fault_latched);
        end
        e_fault = 1'b0;
        e_fault_clear = 1'b0;
        @(negedge clock);
        n_compared++;
        if (e_fault_latched !== 1'b1 || e_pwm_high !== 3'b000) begin
            n_mismatched++;
            $display("[TB] FAIL fault_held: got latched=%b hi=%b expected 1 000",
                     e_fault_latched, e_pwm_high);
        end
        e_fault_clear = 1'b1;
        @(negedge clock);
        e_fault_clear = 1'b0;
        n_compared++;
        if (e_fault_latched !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fault_cleared: got %b expected 0", e_fault_latched);
        end
        for (int c = 24; c <= 29; c++) begin
            if (c > 24) @(negedge clock);
            n_compared++;
            if (e_pwm_high !== ((c == 29) ? 3'b111 : 3'b000) || e_pwm_low !== 3'b000) begin
                n_mismatched++;
                $display("[TB] FAIL resume_count%0d: got hi=%b lo=%b expected hi=%b lo=000",
                         c, e_pwm_high, e_pwm_low, (c == 29) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_back_to_back;
        goto_pos(100, 60);
        load_edge({3{10'd70}});
        goto_pos(100, 70);
        load_edge({3{10'd40}});
        goto_pos(100, 0);
        n_compared++;
        if (e_update_ack !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ack: got %b expected 1", e_update_ack);
        end
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clock);
            n_compared++;
            if (e_pwm_high !== edge_hi(c, 40) || e_pwm_low !== edge_lo(c, 40)) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_count%0d: got hi=%b lo=%b expected hi=%b lo=%b",
                         c, e_pwm_high, e_pwm_low, edge_hi(c, 40), edge_lo(c, 40));
            end
        end
    endtask

    task automatic test_center;
        logic [2:0] exp_hi, exp_lo;
        goto_pos(200, 50);
        c_duty = {3{10'd30}};
        c_duty_load = 1'b1;
        @(negedge clock);
        c_duty_load = 1'b0;
        goto_pos(200, 0);
        n_compared++;
        if (c_update_ack !== 1'b1 || c_period_start !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL center_ack: got ack=%b ps=%b expected 1 1", c_update_ack, c_period_start);
        end
        goto_pos(200, 0);
        for (int p = 0; p < 200; p++) begin
            if (p > 0) @(negedge clock);
            exp_hi = (p >= 176 || p <= 30) ? 3'b111 : 3'b000;
            exp_lo = (p >= 35 && p <= 171) ? 3'b111 : 3'b000;
            n_compared++;
            if (c_pwm_high !== exp_hi || c_pwm_low !== exp_lo) begin
                n_mismatched++;
                $display("[TB] FAIL center_pos%0d: got hi=%b lo=%b expected hi=%b lo=%b",
                         p, c_pwm_high, c_pwm_low, exp_hi, exp_lo);
            end
            if (p == 100) begin
                n_compared++;
                if (c_period_start !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL center_peak_ps: got %b expected 0", c_period_start);
                end
            end
        end
        c_duty = {3{10'd60}};
        c_duty_load = 1'b1;
        @(negedge clock);
        c_duty_load = 1'b0;
        n_compared++;
        if (c_update_ack !== 1'b1 || c_period_start !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bypass_ack: got ack=%b ps=%b expected 1 1", c_update_ack, c_period_start);
        end
        goto_pos(200, 40);
        n_compared++;
        if (c_pwm_high !== 3'b111) begin
            n_mismatched++;
            $display("[TB] FAIL bypass_active: got hi=%b expected 111", c_pwm_high);
        end
        c_high_z = 3'b010;
        @(negedge clock);
        n_compared++;
        if (c_pwm_high !== 3'b101 || c_pwm_low !== 3'b000) begin
            n_mismatched++;
            $display("[TB] FAIL high_z_float: got hi=%b lo=%b expected 101 000", c_pwm_high, c_pwm_low);
        end
        goto_pos(200, 45);
        c_high_z = 3'b000;
        for (int p = 46; p <= 50; p++) begin
            @(negedge clock);
            n_compared++;
            if (c_pwm_high !== ((p == 50) ? 3'b111 : 3'b101) || c_pwm_low !== 3'b000) begin
                n_mismatched++;
                $display("[TB] FAIL high_z_resume_pos%0d: got hi=%b lo=%b expected hi=%b lo=000",
                         p, c_pwm_high, c_pwm_low, (p == 50) ? 3'b111 : 3'b101);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_compared++;
        if ({e_pwm_high, e_pwm_low, c_pwm_high, c_pwm_low} !== 12'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got %b expected all zero",
                     {e_pwm_high, e_pwm_low, c_pwm_high, c_pwm_low});
        end
    endtask

    initial begin
        $display("[TB] starting multi_phase_pwm_driver bench");
        test_reset;
        test_duty_load;
        test_full_and_zero;
        test_swallow_and_clamp;
        test_fault;
        test_back_to_back;
        test_center;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
